// File: rtl/turf_generic_pkg.sv
// turf_generic_pkg: shared types and constants for the TURF generic responder
package turf_generic_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LOCAL, ST_EXT, ST_ACK} state_t;
   localparam logic [3:0] IDX_ID        = 4'd0;
   localparam logic [3:0] IDX_SCRATCH   = 4'd1;
   localparam logic [3:0] IDX_CTRL_BASE = 4'd2;
   localparam logic [3:0] IDX_ERRCNT    = 4'd7;
   localparam logic [3:0] IDX_STAT_BASE = 4'd8;
   localparam logic [31:0] BUS_ERR_DATA = 32'hDEADDEAD;
   localparam int LOCAL_ADR_BITS = 4;
endpackage

// File: rtl/turf_generic_resp.sv
// turf_generic_resp: generic-bus responder with local register bank and timed external port
module turf_generic_resp
   import turf_generic_pkg::*;
#(
   parameter int NCTRL = 4,
   parameter int NSTAT = 4,
   parameter logic [31:0] ID_VALUE = 32'h54524650,
   parameter int WAIT_STATES = 0,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_en_i,
   input  logic                  s_wr_i,
   output logic                  s_ack_o,
   input  logic [27:0]           s_adr_i,
   input  logic [31:0]           s_dat_i,
   output logic [31:0]           s_dat_o,
   output logic [32*NCTRL-1:0]   ctrl_o,
   input  logic [32*NSTAT-1:0]   stat_i,
   output logic                  ext_en_o,
   output logic                  ext_wr_o,
   output logic [27:0]           ext_adr_o,
   output logic [31:0]           ext_dat_o,
   input  logic                  ext_ack_i,
   input  logic [31:0]           ext_dat_i,
   output logic                  err_o
);
   state_t      state;
   logic [3:0]  wcnt;
   logic [15:0] tcnt;
   logic [7:0]  errcnt;
   logic [31:0] scratch;
   logic [31:0] rdata;
   logic [3:0]  idx;
   // The ext_* registers double as the request latch for local accesses too.
   assign idx = ext_adr_o[3:0];
   // Local register read mux, unmapped indices return zero.
   always_comb begin
      rdata = '0;
      if (idx == IDX_ID) rdata = ID_VALUE;
      if (idx == IDX_SCRATCH) rdata = scratch;
      if (idx == IDX_ERRCNT) rdata = {24'd0, errcnt};
      for (int k = 0; k < NCTRL; k++) if (idx == IDX_CTRL_BASE + 4'(k)) rdata = ctrl_o[32*k +: 32];
      for (int k = 0; k < NSTAT; k++) if (idx == IDX_STAT_BASE + 4'(k)) rdata = stat_i[32*k +: 32];
   end
   // Transaction FSM, register bank and error counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         s_ack_o <= 1'b0;
         s_dat_o <= '0;
         ctrl_o <= '0;
         ext_en_o <= 1'b0;
         ext_wr_o <= 1'b0;
         ext_adr_o <= '0;
         ext_dat_o <= '0;
         err_o <= 1'b0;
         wcnt <= '0;
         tcnt <= '0;
         errcnt <= '0;
         scratch <= '0;
      end else begin
         case (state)
            ST_IDLE: if (s_en_i) begin
               ext_wr_o <= s_wr_i;
               ext_adr_o <= s_adr_i;
               ext_dat_o <= s_dat_i;
               wcnt <= 4'(WAIT_STATES);
               tcnt <= '0;
               state <= (s_adr_i[27:LOCAL_ADR_BITS] == '0) ? ST_LOCAL : ST_EXT;
               ext_en_o <= (s_adr_i[27:LOCAL_ADR_BITS] != '0);
            end
            ST_LOCAL: if (wcnt != '0) wcnt <= wcnt - 4'd1;
            else begin
               state <= ST_ACK;
               s_ack_o <= 1'b1;
               s_dat_o <= rdata;
               if (ext_wr_o && idx == IDX_SCRATCH) scratch <= ext_dat_o;
               if (ext_wr_o && idx == IDX_ERRCNT) errcnt <= '0;
               for (int k = 0; k < NCTRL; k++) if (ext_wr_o && idx == IDX_CTRL_BASE + 4'(k)) ctrl_o[32*k +: 32] <= ext_dat_o;
            end
            ST_EXT: if (ext_ack_i || tcnt == 16'(TIMEOUT - 1)) begin
               state <= ST_ACK;
               ext_en_o <= 1'b0;
               s_ack_o <= 1'b1;
               s_dat_o <= ext_ack_i ? ext_dat_i : BUS_ERR_DATA;
               err_o <= !ext_ack_i;
               if (!ext_ack_i && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
            end else tcnt <= tcnt + 16'd1;
            ST_ACK: begin
               state <= ST_IDLE;
               s_ack_o <= 1'b0;
               err_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_turf_generic_resp.sv
// tb_turf_generic_resp: table, hand-written and randomized checks against a transaction-level model
module tb_turf_generic_resp;
   localparam int NCTRL = 4;
   localparam int NSTAT = 4;
   localparam int WS = 0;
   localparam int TIMEOUT = 8;
   localparam logic [31:0] ID = 32'h54524650;
   logic clk, rst, s_en_i, s_wr_i, s_ack_o, ext_en_o, ext_wr_o, ext_ack_i, err_o;
   logic [27:0] s_adr_i, ext_adr_o;
   logic [31:0] s_dat_i, s_dat_o, ext_dat_o, ext_dat_i;
   logic [32*NCTRL-1:0] ctrl_o;
   logic [32*NSTAT-1:0] stat_i;
   int checks = 0;
   int failures = 0;
   logic [31:0] m_scratch;
   logic [31:0] m_ctrl [NCTRL];
   int m_err;

   turf_generic_resp #(.NCTRL(NCTRL), .NSTAT(NSTAT), .ID_VALUE(ID), .WAIT_STATES(WS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .s_en_i(s_en_i), .s_wr_i(s_wr_i), .s_ack_o(s_ack_o), .s_adr_i(s_adr_i),
      .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .ctrl_o(ctrl_o), .stat_i(stat_i), .ext_en_o(ext_en_o),
      .ext_wr_o(ext_wr_o), .ext_adr_o(ext_adr_o), .ext_dat_o(ext_dat_o), .ext_ack_i(ext_ack_i),
      .ext_dat_i(ext_dat_i), .err_o(err_o));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] m_ctrl_flat();
      logic [127:0] v = '0;
      for (int k = 0; k < NCTRL; k++) v[32*k +: 32] = m_ctrl[k];
      return v;
   endfunction

   task automatic m_reset();
      m_scratch = '0;
      m_err = 0;
      for (int k = 0; k < NCTRL; k++) m_ctrl[k] = '0;
   endtask

   function automatic logic [31:0] m_read(input int i);
      if (i == 0) return ID;
      if (i == 1) return m_scratch;
      if (i >= 2 && i < 2 + NCTRL) return m_ctrl[i-2];
      if (i == 7) return 32'(m_err);
      if (i >= 8 && i < 8 + NSTAT) return stat_i[32*(i-8) +: 32];
      return '0;
   endfunction

   task automatic m_step(input logic wr, input logic [27:0] adr, input logic [31:0] dat, input int delay,
                         input logic [31:0] edat, output logic [31:0] rd, output int lat, output int en, output logic err);
      int i;
      err = 0;
      if (adr < 28'h10) begin
         i = int'(adr);
         rd = m_read(i);
         lat = 2 + WS;
         en = 0;
         if (wr && i == 1) m_scratch = dat;
         if (wr && i >= 2 && i < 2 + NCTRL) m_ctrl[i-2] = dat;
         if (wr && i == 7) m_err = 0;
      end else if (delay >= 1 && delay <= TIMEOUT) begin
         rd = edat;
         en = delay;
         lat = delay + 1;
      end else begin
         rd = 32'hDEADDEAD;
         en = TIMEOUT;
         lat = TIMEOUT + 1;
         err = 1;
         m_err = (m_err < 255) ? m_err + 1 : 255;
      end
   endtask

   task automatic run(input logic wr, input logic [27:0] adr, input logic [31:0] dat, input int delay, input logic [31:0] edat,
                      output logic [31:0] rd, output int lat, output int en, output logic err, output logic [127:0] ctl,
                      output logic ext_ok);
      rd = '0; lat = 0; en = 0; err = 0; ctl = '0; ext_ok = 1;
      s_en_i = 1; s_wr_i = wr; s_adr_i = adr; s_dat_i = dat; ext_ack_i = 0;
      for (int n = 1; n <= TIMEOUT + 20 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (ext_en_o) begin
            en++;
            if (ext_adr_o != adr || ext_wr_o != wr || (wr && ext_dat_o != dat)) ext_ok = 0;
            ext_ack_i = (en == delay);
            ext_dat_i = ext_ack_i ? edat : $urandom;
         end else begin
            ext_ack_i = 1'($urandom);
            ext_dat_i = $urandom;
         end
         if (s_ack_o) begin
            lat = n; rd = s_dat_o; err = err_o; ctl = ctrl_o; s_en_i = 0;
         end
      end
      s_en_i = 0;
      ext_ack_i = 0;
      @(posedge clk); #1;
   endtask

   task automatic do_xact(input string name, input logic wr, input logic [27:0] adr, input logic [31:0] dat,
                          input int delay, input logic [31:0] edat);
      logic [31:0] erd, ard;
      int elat, alat, een, aen;
      logic eerr, aerr, ok;
      logic [127:0] actl;
      m_step(wr, adr, dat, delay, edat, erd, elat, een, eerr);
      run(wr, adr, dat, delay, edat, ard, alat, aen, aerr, actl, ok);
      chk({name, " latency"}, alat, elat);
      chk({name, " ext_en cycles"}, aen, een);
      chk({name, " err_o"}, aerr, eerr);
      chk({name, " ctrl_o"}, actl, m_ctrl_flat());
      if (aen > 0) chk({name, " ext request"}, ok, 1'b1);
      if (!wr) chk({name, " s_dat_o"}, ard, erd);
   endtask

   typedef struct {
      logic wr; logic [27:0] adr; logic [31:0] dat; int delay; logic [31:0] edat;
      logic chk_rd; logic [31:0] rd; int lat; int en; logic err;
   } vec_t;
   vec_t tbl [14];

   initial begin
      logic [31:0] rd, xrd;
      int lat, en, xlat, xen, acks;
      logic err, xerr, ok;
      logic [127:0] ctl;
      tbl[0]  = '{0, 28'h0, 0, 0, 0, 1, ID, 2, 0, 0};
      tbl[1]  = '{1, 28'h3, 32'hA5A50001, 0, 0, 0, 0, 2, 0, 0};
      tbl[2]  = '{0, 28'h3, 0, 0, 0, 1, 32'hA5A50001, 2, 0, 0};
      tbl[3]  = '{1, 28'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 2, 0, 0};
      tbl[4]  = '{0, 28'h0, 0, 0, 0, 1, ID, 2, 0, 0};
      tbl[5]  = '{0, 28'h100, 0, 5, 32'h12345678, 1, 32'h12345678, 6, 5, 0};
      tbl[6]  = '{0, 28'h200, 0, 0, 0, 1, 32'hDEADDEAD, 9, 8, 1};
      tbl[7]  = '{0, 28'h7, 0, 0, 0, 1, 32'd1, 2, 0, 0};
      tbl[8]  = '{0, 28'h300, 0, 8, 32'hCAFEF00D, 1, 32'hCAFEF00D, 9, 8, 0};
      tbl[9]  = '{0, 28'h7, 0, 0, 0, 1, 32'd1, 2, 0, 0};
      tbl[10] = '{1, 28'h1, 32'h11223344, 0, 0, 0, 0, 2, 0, 0};
      tbl[11] = '{0, 28'h1, 0, 0, 0, 1, 32'h11223344, 2, 0, 0};
      tbl[12] = '{0, 28'h8, 0, 0, 0, 1, 32'h57A70008, 2, 0, 0};
      tbl[13] = '{0, 28'hF, 0, 0, 0, 1, 32'h0, 2, 0, 0};
      rst = 0; s_en_i = 0; s_wr_i = 0; s_adr_i = '0; s_dat_i = '0; ext_ack_i = 0; ext_dat_i = '0;
      stat_i = {32'h57A7000B, 32'h57A7000A, 32'h57A70009, 32'h57A70008};
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", {s_ack_o, err_o, ext_en_o, ext_wr_o, ext_adr_o, ext_dat_o, s_dat_o}, '0);
      chk("reset ctrl_o", ctrl_o, '0);
      rst = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 14; i++) begin
         m_step(tbl[i].wr, tbl[i].adr, tbl[i].dat, tbl[i].delay, tbl[i].edat, xrd, xlat, xen, xerr);
         run(tbl[i].wr, tbl[i].adr, tbl[i].dat, tbl[i].delay, tbl[i].edat, rd, lat, en, err, ctl, ok);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
         chk($sformatf("vec%0d ext_en cycles", i), en, tbl[i].en);
         chk($sformatf("vec%0d err_o", i), err, tbl[i].err);
         if (tbl[i].chk_rd) chk($sformatf("vec%0d s_dat_o", i), rd, tbl[i].rd);
         if (i == 1) chk("ctrl3 in ack cycle", ctl[63:32], 32'hA5A50001);
      end
      // hold s_en through the ACK cycle: must not start a new transaction
      s_en_i = 1; s_wr_i = 0; s_adr_i = 28'h0;
      acks = 0;
      for (int n = 0; n < 20 && acks == 0; n++) begin
         @(posedge clk); #1;
         if (s_ack_o) acks++;
      end
      chk("held-en first ack", acks, 1);
      @(posedge clk); #1;
      s_en_i = 0;
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (s_ack_o) acks++;
      end
      chk("en during ACK ignored", acks, 0);
      // s_en dropped after being sampled still completes
      s_en_i = 1; s_wr_i = 0; s_adr_i = 28'h1;
      @(posedge clk); #1;
      s_en_i = 0;
      lat = 0;
      for (int n = 2; n < 10 && lat == 0; n++) begin
         @(posedge clk); #1;
         if (s_ack_o) begin lat = n; rd = s_dat_o; end
      end
      chk("dropped-en latency", lat, 2);
      chk("dropped-en data", rd, m_scratch);
      @(posedge clk); #1;
      for (int i = 0; i < 300; i++) do_xact("timeout", 0, 28'h400 + 28'(i), 0, 0, 0);
      do_xact("errcnt sat", 0, 28'h7, 0, 0, 0);
      chk("errcnt saturated", m_err, 255);
      do_xact("errcnt clear wr", 1, 28'h7, 32'h5, 0, 0);
      do_xact("errcnt cleared", 0, 28'h7, 0, 0, 0);
      for (int i = 0; i < 200; i++) begin
         logic [27:0] a;
         stat_i = {$urandom, $urandom, $urandom, $urandom};
         a = ($urandom_range(0, 9) < 6) ? 28'($urandom_range(0, 15)) : 28'($urandom);
         if (a >= 28'h10 && a[27:4] == '0) a[4] = 1'b1;
         do_xact("random", 1'($urandom), a, $urandom, $urandom_range(0, 10), $urandom);
      end
      // reset during an external wait clears everything without acking
      s_en_i = 1; s_wr_i = 0; s_adr_i = 28'h500;
      repeat (3) @(posedge clk);
      #1;
      chk("ext_en before reset", ext_en_o, 1'b1);
      s_en_i = 0;
      #2 rst = 0;
      #1;
      chk("ext_en after async reset", ext_en_o, 1'b0);
      chk("outputs after async reset", {s_ack_o, err_o, s_dat_o, ctrl_o}, '0);
      m_reset();
      @(posedge clk); #3;
      rst = 1;
      acks = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (s_ack_o || ext_en_o) acks++;
      end
      chk("no ack after reset", acks, 0);
      do_xact("post-reset scratch", 0, 28'h1, 0, 0, 0);
      do_xact("post-reset ext", 0, 28'h600, 0, 3, 32'hBEEF0003);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
